// File: rtl/demux_1to8.sv
// Registered 1-to-N demultiplexer: routes D to output line SEL, one cycle later.
// Optional status outputs (active, active_idx) are built when DEMUX_STATUS_EN is defined.
module demux_1to8 #(
  parameter int N_OUT = 8,
  parameter int SEL_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             D,
  input  logic [SEL_W-1:0] SEL,
`ifdef DEMUX_STATUS_EN
  output logic             active,
  output logic [SEL_W-1:0] active_idx,
`endif
  output logic [N_OUT-1:0] Y
);

  logic [N_OUT-1:0] y_next_s;
  logic [N_OUT-1:0] y_r;

  // Decode D/SEL into a one-hot-or-zero vector; out-of-range SEL matches no line
  always_comb begin
    y_next_s = '0;
    for (int i = 0; i < N_OUT; i++) begin
      if (D && (SEL == SEL_W'(i))) begin
        y_next_s[i] = 1'b1;
      end else begin
        y_next_s[i] = 1'b0;
      end
    end
  end

  // Output register: reset wins, otherwise load on enable, hold when idle
  always_ff @(posedge clk) begin
    if (rst) begin
      y_r <= '0;
    end else if (en) begin
      y_r <= y_next_s;
    end else begin
      y_r <= y_r;
    end
  end

  assign Y = y_r;

`ifdef DEMUX_STATUS_EN
  logic             active_r;
  logic [SEL_W-1:0] active_idx_r;

  // Status registers track the loaded Y; the index is retained while Y is zero
  always_ff @(posedge clk) begin
    if (rst) begin
      active_r     <= 1'b0;
      active_idx_r <= '0;
    end else if (en) begin
      active_r <= |y_next_s;
      if (|y_next_s) begin
        active_idx_r <= SEL;
      end else begin
        active_idx_r <= active_idx_r;
      end
    end else begin
      active_r     <= active_r;
      active_idx_r <= active_idx_r;
    end
  end

  assign active     = active_r;
  assign active_idx = active_idx_r;
`endif

endmodule

// File: tb/tb_demux_1to8.sv
// Directed and randomized self-checking bench for demux_1to8 (N_OUT=8, SEL_W=3).
module tb_demux_1to8;

  logic       clk;
  logic       rst;
  logic       en;
  logic       D;
  logic [2:0] SEL;
  logic [7:0] Y;
`ifdef DEMUX_STATUS_EN
  logic       active;
  logic [2:0] active_idx;
`endif

  int checks = 0;
  int errors = 0;

  demux_1to8 #(.N_OUT(8), .SEL_W(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .D          (D),
    .SEL        (SEL),
`ifdef DEMUX_STATUS_EN
    .active     (active),
    .active_idx (active_idx),
`endif
    .Y          (Y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance past one rising edge; outputs are then stable for sampling
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_y(input string name, input logic [7:0] exp);
    checks++;
    if (Y !== exp) begin
      errors++;
      $display("FAIL %s: Y=%b expected %b", name, Y, exp);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; D = 1'b0; SEL = 3'd5;
    tick();
    check_y("reset", 8'b00000000);
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      check_y("d0_sel5", 8'b00000000);
    end
  endtask

  task automatic test_sweep();
    logic [7:0] one_v;
    one_v = 8'b00000001;
    en = 1'b1; D = 1'b1;
    for (int s = 0; s < 8; s++) begin
      SEL = 3'(s);
      tick();
      check_y($sformatf("sweep_sel%0d", s), one_v << s);
    end
  endtask

  task automatic test_hold();
    en = 1'b1; D = 1'b1; SEL = 3'd3;
    tick();
    check_y("load_sel3", 8'b00001000);
    en = 1'b0; D = 1'b0; SEL = 3'd6;
    for (int i = 0; i < 3; i++) begin
      // mid-cycle glitch on en/D/SEL must not be captured
      #2 en = 1'b1; D = 1'b1; SEL = 3'd1;
      #2 en = 1'b0; D = 1'b0; SEL = 3'd6;
      tick();
      check_y("hold", 8'b00001000);
    end
  endtask

  task automatic test_rst_priority();
    en = 1'b1; D = 1'b1; SEL = 3'd7; rst = 1'b1;
    #3;
    check_y("no_async_rst", 8'b00001000);
    tick();
    check_y("rst_priority", 8'b00000000);
    rst = 1'b0;
    tick();
    check_y("after_rst", 8'b10000000);
  endtask

  task automatic test_back_to_back();
    en = 1'b1; D = 1'b1; SEL = 3'd2;
    tick();
    check_y("b2b_sel2", 8'b00000100);
    SEL = 3'd5;
    tick();
    check_y("b2b_sel5", 8'b00100000);
    D = 1'b0;
    tick();
    check_y("b2b_d0", 8'b00000000);
  endtask

`ifdef DEMUX_STATUS_EN
  task automatic test_status();
    en = 1'b1; D = 1'b1; SEL = 3'd4; rst = 1'b0;
    tick();
    check_y("status_y_on", 8'b00010000);
    checks++;
    if (active !== 1'b1 || active_idx !== 3'd4) begin
      errors++;
      $display("FAIL status_on: active=%b idx=%0d expected 1/4", active, active_idx);
    end
    D = 1'b0;
    tick();
    check_y("status_y_off", 8'b00000000);
    checks++;
    if (active !== 1'b0 || active_idx !== 3'd4) begin
      errors++;
      $display("FAIL status_off: active=%b idx=%0d expected 0/4", active, active_idx);
    end
  endtask
`endif

  task automatic test_random();
    logic [7:0] exp_y;
    logic [7:0] one_v;
    int bad;
    one_v = 8'b00000001;
    bad = 0;
    rst = 1'b1;
    tick();
    exp_y = 8'b00000000;
    for (int i = 0; i < 1000; i++) begin
      rst = ($urandom_range(15) == 0);
      en  = 1'($urandom_range(1));
      D   = 1'($urandom_range(1));
      SEL = 3'($urandom_range(7));
      if (rst) begin
        exp_y = 8'b00000000;
      end else if (en) begin
        exp_y = D ? (one_v << SEL) : 8'b00000000;
      end
      tick();
      checks++;
      if (Y !== exp_y || $countones(Y) > 1) begin
        errors++;
        bad++;
        if (bad <= 10) $display("FAIL random cycle %0d: Y=%b expected %b", i, Y, exp_y);
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b0; en = 1'b0; D = 1'b0; SEL = 3'd0;
    test_reset();
    test_sweep();
    test_hold();
    test_rst_priority();
    test_back_to_back();
`ifdef DEMUX_STATUS_EN
    test_status();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
